// File: rtl/lc3_exec_pkg.sv
// lc3_exec_pkg: shared definitions for the LC-3 execute stage.
//   opcode_e     - 4-bit LC-3 opcode (IR[15:12])
//   alu_ctl_e    - E_Control[5:4] ALU operation encodings
//   pc1_sel_e    - E_Control[3:2] address addend-1 selects
//   EC_*         - E_Control field bit positions
//   sext16()     - sign-extend an IR immediate field to 16 bits
package lc3_exec_pkg;

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD   = 4'b0010, OP_ST  = 4'b0011,
    OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR  = 4'b0110, OP_STR = 4'b0111,
    OP_RTI = 4'b1000, OP_NOT = 4'b1001, OP_LDI  = 4'b1010, OP_STI = 4'b1011,
    OP_JMP = 4'b1100, OP_RES = 4'b1101, OP_LEA  = 4'b1110, OP_TRAP = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00, ALU_AND = 2'b01, ALU_NOT = 2'b10, ALU_RSV = 2'b11
  } alu_ctl_e;

  typedef enum logic [1:0] {
    PC1_OFF11 = 2'b00, PC1_OFF9 = 2'b01, PC1_OFF6 = 2'b10, PC1_ZERO = 2'b11
  } pc1_sel_e;

  localparam int EC_ALU_HI = 5;
  localparam int EC_ALU_LO = 4;
  localparam int EC_PC1_HI = 3;
  localparam int EC_PC1_LO = 2;
  localparam int EC_PC2    = 1;
  localparam int EC_OP2    = 0;

  // Sign-extend the low 'width' bits of a 16-bit value.
  function automatic logic [15:0] sext16(input logic [15:0] v, input int width);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = (i < width) ? v[i] : v[width-1];
    return r;
  endfunction

endpackage

// File: rtl/lc3_execute_if.sv
// lc3_execute_if: decode -> execute -> memory/writeback bundle.
//   master : the decode side (drives operands/control, reads results)
//   slave  : the execute stage
interface lc3_execute_if;
  logic        enable_execute;
  logic [5:0]  E_Control;
  logic [15:0] IR;
  logic [15:0] npc_in;
  logic        Mem_Control_in;
  logic [1:0]  W_Control_in;
  logic [15:0] VSR1, VSR2;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [15:0] Mem_Bypass_Val;
  logic [15:0] aluout, pcout, M_Data, IR_Exec;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out;
  logic [2:0]  dr, sr1, sr2, NZP;

  modport master (
    output enable_execute, E_Control, IR, npc_in, Mem_Control_in, W_Control_in,
           VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
           Mem_Bypass_Val,
    input  aluout, pcout, M_Data, IR_Exec, W_Control_out, Mem_Control_out,
           dr, sr1, sr2, NZP
  );

  modport slave (
    input  enable_execute, E_Control, IR, npc_in, Mem_Control_in, W_Control_in,
           VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
           Mem_Bypass_Val,
    output aluout, pcout, M_Data, IR_Exec, W_Control_out, Mem_Control_out,
           dr, sr1, sr2, NZP
  );
endinterface

// File: rtl/lc3_exec_alu.sv
// lc3_exec_alu: combinational 16-bit ALU for the execute stage.
//   ctl : ADD / AND / NOT (reserved encoding behaves as ADD)
//   op1, op2 : operands; y : result (ADD wraps mod 2^16)
module lc3_exec_alu
  import lc3_exec_pkg::*;
(
  input  alu_ctl_e    ctl,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  output logic [15:0] y
);
  always_comb begin
    y = op1 + op2;
    case (ctl)
      ALU_AND: y = op1 & op2;
      ALU_NOT: y = ~op1;
      default: y = op1 + op2;
    endcase
  end
endmodule

// File: rtl/lc3_execute.sv
// lc3_execute: LC-3 pipeline execute stage, one-cycle latency.
//   clock, reset : rising-edge clock, async active-high reset
//   bus (slave)  : decode inputs, registered results, combinational sr1/sr2
// Optional feature: define LC3_EXEC_BYPASS_EN to enable operand forwarding
// from aluout (priority) or Mem_Bypass_Val; otherwise bypass inputs are ignored.
module lc3_execute
  import lc3_exec_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  lc3_execute_if.slave bus
);
  opcode_e     opcode;
  logic        is_store, is_alu_op, writes_dr;
  logic [15:0] vsr1_fwd, vsr2_fwd, op2, alu_y;
  logic [15:0] addend1, addend2, pc_sum;

  assign opcode    = opcode_e'(bus.IR[15:12]);
  assign is_store  = (opcode == OP_ST) || (opcode == OP_STR) || (opcode == OP_STI);
  assign is_alu_op = (opcode == OP_ADD) || (opcode == OP_AND) || (opcode == OP_NOT);
  assign writes_dr = is_alu_op || (opcode == OP_LEA) || (opcode == OP_LD) ||
                     (opcode == OP_LDR) || (opcode == OP_LDI);

  // Stores read their source from IR[11:9], so sr2 follows the opcode.
  assign bus.sr1 = bus.IR[8:6];
  assign bus.sr2 = is_store ? bus.IR[11:9] : bus.IR[2:0];

`ifdef LC3_EXEC_BYPASS_EN
  assign vsr1_fwd = bus.bypass_alu_1 ? bus.aluout :
                    bus.bypass_mem_1 ? bus.Mem_Bypass_Val : bus.VSR1;
  assign vsr2_fwd = bus.bypass_alu_2 ? bus.aluout :
                    bus.bypass_mem_2 ? bus.Mem_Bypass_Val : bus.VSR2;
`else
  logic unused_bypass;
  assign unused_bypass = ^{bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1,
                           bus.bypass_mem_2, bus.Mem_Bypass_Val};
  assign vsr1_fwd = bus.VSR1;
  assign vsr2_fwd = bus.VSR2;
`endif

  assign op2 = bus.E_Control[EC_OP2] ? vsr2_fwd : sext16(bus.IR, 5);

  lc3_exec_alu u_alu (
    .ctl (alu_ctl_e'(bus.E_Control[EC_ALU_HI:EC_ALU_LO])),
    .op1 (vsr1_fwd),
    .op2 (op2),
    .y   (alu_y)
  );

  always_comb begin
    addend1 = '0;
    case (pc1_sel_e'(bus.E_Control[EC_PC1_HI:EC_PC1_LO]))
      PC1_OFF11: addend1 = sext16(bus.IR, 11);
      PC1_OFF9:  addend1 = sext16(bus.IR, 9);
      PC1_OFF6:  addend1 = sext16(bus.IR, 6);
      default:   addend1 = '0;
    endcase
  end

  // The base register goes through forwarding too, so LDR/STR/JMP see fresh data.
  assign addend2 = bus.E_Control[EC_PC2] ? bus.npc_in : vsr1_fwd;
  assign pc_sum  = addend1 + addend2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.aluout          <= '0;
      bus.pcout           <= '0;
      bus.M_Data          <= '0;
      bus.IR_Exec         <= '0;
      bus.W_Control_out   <= '0;
      bus.Mem_Control_out <= 1'b0;
      bus.dr              <= '0;
      bus.NZP             <= '0;
    end else if (bus.enable_execute) begin
      if (is_alu_op)            bus.aluout <= alu_y;
      else if (opcode == OP_LEA) bus.aluout <= pc_sum;
      bus.pcout           <= pc_sum;
      bus.M_Data          <= is_store ? vsr2_fwd : 16'h0000;
      bus.IR_Exec         <= bus.IR;
      bus.W_Control_out   <= bus.W_Control_in;
      bus.Mem_Control_out <= bus.Mem_Control_in;
      bus.dr              <= writes_dr ? bus.IR[11:9] : 3'b000;
      // Non-branch instructions load 0, so the mask lives one enabled cycle.
      bus.NZP             <= (opcode == OP_BR)  ? bus.IR[11:9] :
                             (opcode == OP_JMP) ? 3'b111 : 3'b000;
    end
  end
endmodule

// File: tb/tb_lc3_execute.sv
// tb_lc3_execute: directed self-checking bench for lc3_execute.
module tb_lc3_execute;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  lc3_execute_if bus ();
  lc3_execute dut (.clock(clock), .reset(reset), .bus(bus.slave));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] ir, input logic [5:0] ec,
                       input logic [15:0] v1, input logic [15:0] v2,
                       input logic [15:0] npc);
    bus.IR = ir; bus.E_Control = ec; bus.VSR1 = v1; bus.VSR2 = v2; bus.npc_in = npc;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++; if (bus.aluout !== 16'h0) $display("FAIL rst_aluout got=%h exp=0000", bus.aluout); else pass_cnt++;
    total_cnt++; if (bus.pcout !== 16'h0) $display("FAIL rst_pcout got=%h exp=0000", bus.pcout); else pass_cnt++;
    total_cnt++; if ({bus.NZP, bus.dr, bus.W_Control_out, bus.Mem_Control_out} !== 9'h0)
      $display("FAIL rst_ctl got=%h exp=000", {bus.NZP, bus.dr, bus.W_Control_out, bus.Mem_Control_out}); else pass_cnt++;
    total_cnt++; if ({bus.M_Data, bus.IR_Exec} !== 32'h0) $display("FAIL rst_data got=%h exp=0", {bus.M_Data, bus.IR_Exec}); else pass_cnt++;
    reset = 1'b0;
    #3;
  endtask

  task automatic test_add_reg();
    drive(16'h1283, 6'b000001, 16'd5, 16'd7, 16'h3000);
    bus.W_Control_in = 2'b10; bus.Mem_Control_in = 1'b1; bus.enable_execute = 1'b1;
    #1;
    total_cnt++; if (bus.sr1 !== 3'd2) $display("FAIL add_sr1 got=%0d exp=2", bus.sr1); else pass_cnt++;
    total_cnt++; if (bus.sr2 !== 3'd3) $display("FAIL add_sr2 got=%0d exp=3", bus.sr2); else pass_cnt++;
    tick();
    total_cnt++; if (bus.aluout !== 16'd12) $display("FAIL add_aluout got=%h exp=000c", bus.aluout); else pass_cnt++;
    total_cnt++; if (bus.dr !== 3'd1) $display("FAIL add_dr got=%0d exp=1", bus.dr); else pass_cnt++;
    total_cnt++; if (bus.IR_Exec !== 16'h1283) $display("FAIL add_irexec got=%h exp=1283", bus.IR_Exec); else pass_cnt++;
    total_cnt++; if ({bus.W_Control_out, bus.Mem_Control_out} !== 3'b101)
      $display("FAIL add_passthru got=%b exp=101", {bus.W_Control_out, bus.Mem_Control_out}); else pass_cnt++;
    bus.W_Control_in = 2'b00; bus.Mem_Control_in = 1'b0;
  endtask

  task automatic test_add_imm();
    drive(16'h12BF, 6'b000000, 16'd0, 16'd7, 16'h3000);
    tick();
    total_cnt++; if (bus.aluout !== 16'hFFFF) $display("FAIL addimm_aluout got=%h exp=ffff", bus.aluout); else pass_cnt++;
  endtask

  task automatic test_br();
    drive(16'h0A05, 6'b000110, 16'h1111, 16'h2222, 16'h3001);
    tick();
    total_cnt++; if (bus.pcout !== 16'h3006) $display("FAIL br_pcout got=%h exp=3006", bus.pcout); else pass_cnt++;
    total_cnt++; if (bus.NZP !== 3'b101) $display("FAIL br_nzp got=%b exp=101", bus.NZP); else pass_cnt++;
    total_cnt++; if (bus.aluout !== 16'hFFFF) $display("FAIL br_aluout_hold got=%h exp=ffff", bus.aluout); else pass_cnt++;
    total_cnt++; if (bus.dr !== 3'd0) $display("FAIL br_dr got=%0d exp=0", bus.dr); else pass_cnt++;
    drive(16'h0000, 6'b000110, 16'h0, 16'h0, 16'h3002);
    tick();
    total_cnt++; if (bus.NZP !== 3'b000) $display("FAIL nop_nzp got=%b exp=000", bus.NZP); else pass_cnt++;
  endtask

  task automatic test_str();
    drive(16'h7682, 6'b001000, 16'h4000, 16'hBEEF, 16'h3003);
    #1;
    total_cnt++; if (bus.sr2 !== 3'd3) $display("FAIL str_sr2 got=%0d exp=3", bus.sr2); else pass_cnt++;
    tick();
    total_cnt++; if (bus.pcout !== 16'h4002) $display("FAIL str_pcout got=%h exp=4002", bus.pcout); else pass_cnt++;
    total_cnt++; if (bus.M_Data !== 16'hBEEF) $display("FAIL str_mdata got=%h exp=beef", bus.M_Data); else pass_cnt++;
    total_cnt++; if (bus.dr !== 3'd0) $display("FAIL str_dr got=%0d exp=0", bus.dr); else pass_cnt++;
  endtask

  task automatic test_logic();
    drive(16'h5283, 6'b010001, 16'hF0F0, 16'h3C3C, 16'h3000);
    tick();
    total_cnt++; if (bus.aluout !== 16'h3030) $display("FAIL and_aluout got=%h exp=3030", bus.aluout); else pass_cnt++;
    total_cnt++; if (bus.M_Data !== 16'h0) $display("FAIL and_mdata got=%h exp=0000", bus.M_Data); else pass_cnt++;
    drive(16'h96BF, 6'b100000, 16'h00FF, 16'h0, 16'h3000);
    tick();
    total_cnt++; if (bus.aluout !== 16'hFF00) $display("FAIL not_aluout got=%h exp=ff00", bus.aluout); else pass_cnt++;
    drive(16'hE403, 6'b000110, 16'h0, 16'h0, 16'h3000);
    tick();
    total_cnt++; if (bus.aluout !== 16'h3003) $display("FAIL lea_aluout got=%h exp=3003", bus.aluout); else pass_cnt++;
    total_cnt++; if (bus.dr !== 3'd2) $display("FAIL lea_dr got=%0d exp=2", bus.dr); else pass_cnt++;
    drive(16'h2A05, 6'b000110, 16'h0, 16'h0, 16'h3000);
    tick();
    total_cnt++; if (bus.dr !== 3'd5) $display("FAIL ld_dr got=%0d exp=5", bus.dr); else pass_cnt++;
    total_cnt++; if (bus.aluout !== 16'h3003) $display("FAIL ld_aluout_hold got=%h exp=3003", bus.aluout); else pass_cnt++;
    drive(16'hB600, 6'b000110, 16'h0, 16'h0, 16'h3000);
    #1;
    total_cnt++; if (bus.sr2 !== 3'd3) $display("FAIL sti_sr2 got=%0d exp=3", bus.sr2); else pass_cnt++;
    drive(16'hC080, 6'b001100, 16'h1234, 16'h0, 16'h3000);
    tick();
    total_cnt++; if (bus.pcout !== 16'h1234) $display("FAIL jmp_pcout got=%h exp=1234", bus.pcout); else pass_cnt++;
    total_cnt++; if (bus.NZP !== 3'b111) $display("FAIL jmp_nzp got=%b exp=111", bus.NZP); else pass_cnt++;
  endtask

  task automatic test_hold();
    bus.enable_execute = 1'b0;
    drive(16'h1283, 6'b000001, 16'd5, 16'd7, 16'h5000);
    #1;
    total_cnt++; if (bus.sr1 !== 3'd2) $display("FAIL hold_sr1 got=%0d exp=2", bus.sr1); else pass_cnt++;
    tick();
    total_cnt++; if (bus.aluout !== 16'h3003) $display("FAIL hold_aluout got=%h exp=3003", bus.aluout); else pass_cnt++;
    total_cnt++; if (bus.pcout !== 16'h1234) $display("FAIL hold_pcout got=%h exp=1234", bus.pcout); else pass_cnt++;
    total_cnt++; if (bus.NZP !== 3'b111) $display("FAIL hold_nzp got=%b exp=111", bus.NZP); else pass_cnt++;
    total_cnt++; if (bus.IR_Exec !== 16'hC080) $display("FAIL hold_irexec got=%h exp=c080", bus.IR_Exec); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    #1;
    reset = 1'b1;
    #1;
    total_cnt++; if ({bus.aluout, bus.pcout, bus.IR_Exec} !== 48'h0)
      $display("FAIL midrst_data got=%h exp=0", {bus.aluout, bus.pcout, bus.IR_Exec}); else pass_cnt++;
    total_cnt++; if (bus.NZP !== 3'b000) $display("FAIL midrst_nzp got=%b exp=000", bus.NZP); else pass_cnt++;
    reset = 1'b0;
    drive(16'h12BF, 6'b000000, 16'd0, 16'd0, 16'h3000);
    bus.enable_execute = 1'b1;
    tick();
    total_cnt++; if (bus.aluout !== 16'hFFFF) $display("FAIL resume_aluout got=%h exp=ffff", bus.aluout); else pass_cnt++;
  endtask

  task automatic test_bypass();
    logic [15:0] exp_a, exp_b, exp_c;
`ifdef LC3_EXEC_BYPASS_EN
    exp_a = 16'd11; exp_b = 16'd12; exp_c = 16'd501;
`else
    exp_a = 16'd100; exp_b = 16'd100; exp_c = 16'd100;
`endif
    drive(16'h102A, 6'b000000, 16'd0, 16'd0, 16'h3000);
    tick();
    total_cnt++; if (bus.aluout !== 16'd10) $display("FAIL byp_setup got=%h exp=000a", bus.aluout); else pass_cnt++;
    bus.bypass_alu_1 = 1'b1; bus.Mem_Bypass_Val = 16'd500;
    drive(16'h1021, 6'b000000, 16'd99, 16'd0, 16'h3000);
    tick();
    total_cnt++; if (bus.aluout !== exp_a) $display("FAIL byp_alu got=%h exp=%h", bus.aluout, exp_a); else pass_cnt++;
    bus.bypass_mem_1 = 1'b1;
    tick();
    total_cnt++; if (bus.aluout !== exp_b) $display("FAIL byp_prio got=%h exp=%h", bus.aluout, exp_b); else pass_cnt++;
    bus.bypass_alu_1 = 1'b0;
    tick();
    total_cnt++; if (bus.aluout !== exp_c) $display("FAIL byp_mem got=%h exp=%h", bus.aluout, exp_c); else pass_cnt++;
    bus.bypass_mem_1 = 1'b0;
  endtask

  initial begin
    bus.enable_execute = 1'b0; bus.E_Control = '0; bus.IR = '0; bus.npc_in = '0;
    bus.Mem_Control_in = 1'b0; bus.W_Control_in = '0; bus.VSR1 = '0; bus.VSR2 = '0;
    bus.bypass_alu_1 = 1'b0; bus.bypass_alu_2 = 1'b0;
    bus.bypass_mem_1 = 1'b0; bus.bypass_mem_2 = 1'b0; bus.Mem_Bypass_Val = '0;
    test_reset();
    test_add_reg();
    test_add_imm();
    test_br();
    test_str();
    test_logic();
    test_hold();
    test_reset_mid();
    test_bypass();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
